// File: rtl/fixed_adder_bcast.sv
// Two-stage signed fixed-point add/subtract with operand-1 broadcast.
// Stage 1 aligns and adds at full precision; stage 2 casts to the output format.
module fixed_adder_bcast #(
    parameter int DATA_IN_0_PRECISION_0  = 16,
    parameter int DATA_IN_0_PRECISION_1  = 3,
    parameter int DATA_IN_1_PRECISION_0  = 16,
    parameter int DATA_IN_1_PRECISION_1  = 3,
    parameter int DATA_OUT_0_PRECISION_0 = 16,
    parameter int DATA_OUT_0_PRECISION_1 = 3,
    parameter int PARALLELISM            = 4,
    parameter int BCAST_BEATS            = 1,
    parameter int SATURATE               = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0 [PARALLELISM],
    input  logic                              data_in_0_valid,
    output logic                              data_in_0_ready,
    input  logic                              mode_sub,
    input  logic [DATA_IN_1_PRECISION_0-1:0]  data_in_1 [PARALLELISM],
    input  logic                              data_in_1_valid,
    output logic                              data_in_1_ready,
    output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0 [PARALLELISM],
    output logic                              data_out_0_valid,
    input  logic                              data_out_0_ready
);

    localparam int P0       = DATA_IN_0_PRECISION_0;
    localparam int F0       = DATA_IN_0_PRECISION_1;
    localparam int P1       = DATA_IN_1_PRECISION_0;
    localparam int F1       = DATA_IN_1_PRECISION_1;
    localparam int WO       = DATA_OUT_0_PRECISION_0;
    localparam int FO       = DATA_OUT_0_PRECISION_1;
    localparam int FRAC_MAX = (F0 > F1) ? F0 : F1;
    localparam int INT0     = P0 - F0;
    localparam int INT1     = P1 - F1;
    localparam int INT_MAX  = (INT0 > INT1) ? INT0 : INT1;
    localparam int W        = INT_MAX + FRAC_MAX + 1;
    localparam int SH0      = FRAC_MAX - F0;
    localparam int SH1      = FRAC_MAX - F1;
    localparam int PAD      = (FO > FRAC_MAX) ? FO - FRAC_MAX : 0;
    localparam int TRUNC    = (FRAC_MAX > FO) ? FRAC_MAX - FO : 0;
    localparam int WA       = W + PAD;
    localparam int WX       = (WA > WO) ? WA : WO;
    localparam int CW       = (BCAST_BEATS > 1) ? $clog2(BCAST_BEATS) : 1;

    localparam logic [CW-1:0]        LAST  = CW'(BCAST_BEATS - 1);
    localparam logic signed [WX-1:0] MAX_V = {{(WX-WO+1){1'b0}}, {(WO-1){1'b1}}};
    localparam logic signed [WX-1:0] MIN_V = {{(WX-WO+1){1'b1}}, {(WO-1){1'b0}}};

    // Handshakes: a beat transfers on a rising clk edge where valid && ready;
    // a source holds valid/data until then, and no ready here looks at its own valid.
    logic                 b_v;
    logic [P1-1:0]        b_reg [PARALLELISM];
    logic [CW-1:0]        cnt;
    logic                 s1_v;
    logic signed [W-1:0]  s1_sum [PARALLELISM];

    logic                 in0_fire;
    logic                 in1_fire;
    logic                 last_fire;
    logic                 s1_en;
    logic                 s2_en;

    logic [W-1:0]         a_ext   [PARALLELISM];
    logic [W-1:0]         b_ext   [PARALLELISM];
    logic signed [W-1:0]  sum_c   [PARALLELISM];
    logic signed [WX-1:0] ext_c   [PARALLELISM];
    logic signed [WX-1:0] aligned [PARALLELISM];
    logic [WO-1:0]        cast_c  [PARALLELISM];

    assign s2_en           = !data_out_0_valid || data_out_0_ready;
    assign s1_en           = !s1_v || s2_en;
    assign data_in_0_ready = s1_en && b_v;
    assign in0_fire        = data_in_0_valid && data_in_0_ready;
    assign last_fire       = in0_fire && (cnt == LAST);
    assign data_in_1_ready = !b_v || last_fire;
    assign in1_fire        = data_in_1_valid && data_in_1_ready;

    // Both operands are brought to FRAC_MAX fraction bits; W keeps one spare
    // integer bit so the add/subtract can never overflow.
    always_comb begin
        for (int i = 0; i < PARALLELISM; i++) begin
            a_ext[i] = '0;
            b_ext[i] = '0;
            sum_c[i] = '0;
            a_ext[i] = {{(W-P0){data_in_0[i][P0-1]}}, data_in_0[i]} << SH0;
            b_ext[i] = {{(W-P1){b_reg[i][P1-1]}}, b_reg[i]} << SH1;
            if (mode_sub) begin
                sum_c[i] = a_ext[i] - b_ext[i];
            end else begin
                sum_c[i] = a_ext[i] + b_ext[i];
            end
        end
    end

    // Output cast: floor on dropped fraction bits, then clamp or wrap.
    always_comb begin
        for (int i = 0; i < PARALLELISM; i++) begin
            ext_c[i]   = '0;
            aligned[i] = '0;
            cast_c[i]  = '0;
            ext_c[i]   = WX'(s1_sum[i]);
            aligned[i] = ext_c[i] <<< PAD;
            aligned[i] = aligned[i] >>> TRUNC;
            if ((SATURATE != 0) && (aligned[i] > MAX_V)) begin
                cast_c[i] = MAX_V[WO-1:0];
            end else if ((SATURATE != 0) && (aligned[i] < MIN_V)) begin
                cast_c[i] = MIN_V[WO-1:0];
            end else begin
                cast_c[i] = aligned[i][WO-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_v              <= 1'b0;
            cnt              <= '0;
            s1_v             <= 1'b0;
            data_out_0_valid <= 1'b0;
            for (int i = 0; i < PARALLELISM; i++) begin
                b_reg[i]      <= '0;
                s1_sum[i]     <= '0;
                data_out_0[i] <= '0;
            end
        end else begin
            // A reload in the same cycle as the last reuse keeps b_v high.
            if (in1_fire) begin
                b_v <= 1'b1;
                for (int i = 0; i < PARALLELISM; i++) begin
                    b_reg[i] <= data_in_1[i];
                end
            end else if (last_fire) begin
                b_v <= 1'b0;
            end

            if (in0_fire) begin
                cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            end

            if (s1_en) begin
                s1_v <= in0_fire;
                if (in0_fire) begin
                    for (int i = 0; i < PARALLELISM; i++) begin
                        s1_sum[i] <= sum_c[i];
                    end
                end
            end

            if (s2_en) begin
                data_out_0_valid <= s1_v;
                if (s1_v) begin
                    for (int i = 0; i < PARALLELISM; i++) begin
                        data_out_0[i] <= cast_c[i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fixed_adder_bcast.sv
// Bench for fixed_adder_bcast: four instances (default, wrapping, broadcast,
// mixed precision) share one stimulus bus; sel picks whose outputs are observed.
module tb_fixed_adder_bcast;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic        m;
        logic [63:0] e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in0 [4];
    logic        in0_valid;
    logic        mode;
    logic [15:0] in1 [4];
    logic        in1_valid;
    logic        out_ready;

    logic        rdy0_a, rdy0_w, rdy0_b, rdy0_m;
    logic        rdy1_a, rdy1_w, rdy1_b, rdy1_m;
    logic        ov_a, ov_w, ov_b, ov_m;
    logic [15:0] od_a [4];
    logic [15:0] od_w [4];
    logic [15:0] od_b [4];
    logic [15:0] od_m [4];

    int          sel;
    logic        in0_ready_s, in1_ready_s, out_valid_s;
    logic [63:0] out_pk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_q [$];
    vec_t        vecs [19];
    int          run_len = 0;
    int          max_run = 0;
    bit          hold_chk = 1'b0;
    logic [63:0] hold_data;

    always #5 clk = ~clk;

    fixed_adder_bcast dut_a (
        .clk(clk), .rst(rst),
        .data_in_0(in0), .data_in_0_valid(in0_valid), .data_in_0_ready(rdy0_a),
        .mode_sub(mode),
        .data_in_1(in1), .data_in_1_valid(in1_valid), .data_in_1_ready(rdy1_a),
        .data_out_0(od_a), .data_out_0_valid(ov_a), .data_out_0_ready(out_ready)
    );

    fixed_adder_bcast #(.SATURATE(0)) dut_w (
        .clk(clk), .rst(rst),
        .data_in_0(in0), .data_in_0_valid(in0_valid), .data_in_0_ready(rdy0_w),
        .mode_sub(mode),
        .data_in_1(in1), .data_in_1_valid(in1_valid), .data_in_1_ready(rdy1_w),
        .data_out_0(od_w), .data_out_0_valid(ov_w), .data_out_0_ready(out_ready)
    );

    fixed_adder_bcast #(.BCAST_BEATS(4)) dut_b (
        .clk(clk), .rst(rst),
        .data_in_0(in0), .data_in_0_valid(in0_valid), .data_in_0_ready(rdy0_b),
        .mode_sub(mode),
        .data_in_1(in1), .data_in_1_valid(in1_valid), .data_in_1_ready(rdy1_b),
        .data_out_0(od_b), .data_out_0_valid(ov_b), .data_out_0_ready(out_ready)
    );

    fixed_adder_bcast #(.DATA_IN_1_PRECISION_1(5)) dut_m (
        .clk(clk), .rst(rst),
        .data_in_0(in0), .data_in_0_valid(in0_valid), .data_in_0_ready(rdy0_m),
        .mode_sub(mode),
        .data_in_1(in1), .data_in_1_valid(in1_valid), .data_in_1_ready(rdy1_m),
        .data_out_0(od_m), .data_out_0_valid(ov_m), .data_out_0_ready(out_ready)
    );

    always_comb begin
        in0_ready_s = 1'b0;
        in1_ready_s = 1'b0;
        out_valid_s = 1'b0;
        out_pk      = '0;
        case (sel)
            0: begin
                in0_ready_s = rdy0_a; in1_ready_s = rdy1_a; out_valid_s = ov_a;
                for (int l = 0; l < 4; l++) out_pk[16*l +: 16] = od_a[l];
            end
            1: begin
                in0_ready_s = rdy0_w; in1_ready_s = rdy1_w; out_valid_s = ov_w;
                for (int l = 0; l < 4; l++) out_pk[16*l +: 16] = od_w[l];
            end
            2: begin
                in0_ready_s = rdy0_b; in1_ready_s = rdy1_b; out_valid_s = ov_b;
                for (int l = 0; l < 4; l++) out_pk[16*l +: 16] = od_b[l];
            end
            default: begin
                in0_ready_s = rdy0_m; in1_ready_s = rdy1_m; out_valid_s = ov_m;
                for (int l = 0; l < 4; l++) out_pk[16*l +: 16] = od_m[l];
            end
        endcase
    end

    function automatic logic [63:0] mk4(input int x0, input int x1, input int x2, input int x3);
        logic [63:0] r;
        r[15:0]  = 16'(x0);
        r[31:16] = 16'(x1);
        r[47:32] = 16'(x2);
        r[63:48] = 16'(x3);
        return r;
    endfunction

    function automatic vec_t mkv(input logic [63:0] a, input logic [63:0] b,
                                 input logic m, input logic [63:0] e);
        vec_t v;
        v.a = a; v.b = b; v.m = m; v.e = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in0(input logic [63:0] v);
        for (int l = 0; l < 4; l++) in0[l] = v[16*l +: 16];
    endtask

    task automatic set_in1(input logic [63:0] v);
        for (int l = 0; l < 4; l++) in1[l] = v[16*l +: 16];
    endtask

    // Output scoreboard and hold-stability monitor, sampled on the falling edge.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_chk = 1'b0;
                run_len  = 0;
            end else begin
                if (hold_chk) begin
                    check("hold_valid", 64'(out_valid_s), 64'd1);
                    check("hold_data", out_pk, hold_data);
                end
                hold_chk  = out_valid_s && !out_ready;
                hold_data = out_pk;
                run_len   = out_valid_s ? run_len + 1 : 0;
                if (run_len > max_run) max_run = run_len;
                if (out_valid_s && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", out_pk, 64'hx);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", out_pk, e);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_rdy(input int which, output bit ok);
        int t = 0;
        @(negedge clk);
        while (!((which == 0) ? in0_ready_s : in1_ready_s) && t < 200) begin
            @(negedge clk);
            t++;
        end
        ok = (which == 0) ? in0_ready_s : in1_ready_s;
        if (!ok) check("ready_timeout", 64'(which), 64'hx);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() > 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic reset_dut(input int s);
        sel       = s;
        rst       = 1'b1;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        mode      = 1'b0;
        out_ready = 1'b1;
        set_in0('0);
        set_in1('0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_vecs(input int first, input int n);
        fork
            begin
                bit ok;
                for (int i = first; i < first + n; i++) begin
                    set_in0(vecs[i].a);
                    mode      = vecs[i].m;
                    in0_valid = 1'b1;
                    wait_rdy(0, ok);
                    if (ok) exp_q.push_back(vecs[i].e);
                    @(posedge clk); #1;
                end
                in0_valid = 1'b0;
            end
            begin
                bit ok;
                for (int i = first; i < first + n; i++) begin
                    set_in1(vecs[i].b);
                    in1_valid = 1'b1;
                    wait_rdy(1, ok);
                    @(posedge clk); #1;
                end
                in1_valid = 1'b0;
            end
        join
        drain();
    endtask

    initial begin
        bit ok;
        int hi_cnt;

        for (int i = 0; i < 8; i++)
            vecs[i] = mkv(mk4(12, 12, 12, 12), mk4(20, 20, 20, 20), 1'b0, mk4(32, 32, 32, 32));
        vecs[8]  = mkv(mk4(12, 12, 12, 12), mk4(20, 20, 20, 20), 1'b1, mk4(-8, -8, -8, -8));
        vecs[9]  = mkv(mk4(12, 12, 12, 12), mk4(20, 20, 20, 20), 1'b0, mk4(32, 32, 32, 32));
        vecs[10] = mkv(mk4(12, 12, 12, 12), mk4(20, 20, 20, 20), 1'b1, mk4(-8, -8, -8, -8));
        vecs[11] = mkv(mk4(12, 12, 12, 12), mk4(20, 20, 20, 20), 1'b0, mk4(32, 32, 32, 32));
        vecs[12] = mkv(mk4(32767, -32768, 100, -5), mk4(1, -1, -200, 3), 1'b0,
                       mk4(32767, -32768, -100, -2));
        vecs[13] = mkv(mk4(32767, -32768, 0, -32768), mk4(-1, 1, -32768, -32768), 1'b1,
                       mk4(32767, -32768, 32767, 0));
        vecs[14] = mkv(mk4(32767, -32768, 1000, -1000), mk4(1, -1, -3, 3), 1'b0,
                       mk4(-32768, 32767, 997, -997));
        vecs[15] = mkv(mk4(-32768, 32767, 5, 0), mk4(1, -1, 7, 0), 1'b1,
                       mk4(32767, -32768, -2, 0));
        vecs[16] = mkv(mk4(4, 4, 4, 4), mk4(17, 17, 17, 17), 1'b0, mk4(8, 8, 8, 8));
        vecs[17] = mkv(mk4(4, 0, 8, -4), mk4(17, 3, -1, 3), 1'b0, mk4(8, 0, 7, -4));
        vecs[18] = mkv(mk4(4, 4, 0, 100), mk4(17, 16, 1, 0), 1'b1, mk4(-1, 0, -1, 100));

        // Reset state on the default instance.
        reset_dut(0);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid_s), 64'd0);
        check("rst_out_data", out_pk, 64'd0);
        check("rst_in0_ready", 64'(in0_ready_s), 64'd0);
        check("rst_in1_ready", 64'(in1_ready_s), 64'd1);
        @(posedge clk); #1;

        // Single beat latency: 12 + 20 -> 32 two cycles after the handshake.
        set_in1(mk4(20, 20, 20, 20));
        in1_valid = 1'b1;
        wait_rdy(1, ok);
        @(posedge clk); #1;
        in1_valid = 1'b0;
        set_in0(mk4(12, 12, 12, 12));
        in0_valid = 1'b1;
        wait_rdy(0, ok);
        if (ok) exp_q.push_back(mk4(32, 32, 32, 32));
        @(posedge clk); #1;
        in0_valid = 1'b0;
        @(negedge clk);
        check("lat_cycle1_valid", 64'(out_valid_s), 64'd0);
        @(negedge clk);
        check("lat_cycle2_valid", 64'(out_valid_s), 64'd1);
        drain();

        // Eight back-to-back beats give eight consecutive valid cycles.
        max_run = 0;
        run_vecs(0, 8);
        check("b2b_valid_run", 64'(max_run), 64'd8);

        // Mode toggling and saturation.
        run_vecs(8, 6);

        // Downstream stall mid-stream: two beats held, input blocked.
        fork
            run_vecs(0, 12);
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(negedge clk);
                check("bp_in0_ready", 64'(in0_ready_s), 64'd0);
                check("bp_buffered", 64'(exp_q.size()), 64'd2);
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join

        // Reset mid-stream drops the in-flight beat and the held operand.
        reset_dut(0);
        @(posedge clk); #1;
        set_in1(mk4(20, 20, 20, 20));
        in1_valid = 1'b1;
        wait_rdy(1, ok);
        @(posedge clk); #1;
        set_in0(mk4(12, 12, 12, 12));
        in0_valid = 1'b1;
        wait_rdy(0, ok);
        check("reload_in1_ready", 64'(in1_ready_s), 64'd1);
        @(posedge clk); #1;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        rst       = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", 64'(out_valid_s), 64'd0);
        check("mid_rst_in1_ready", 64'(in1_ready_s), 64'd1);
        check("mid_rst_in0_ready", 64'(in0_ready_s), 64'd0);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;

        // Wrapping instance.
        reset_dut(1);
        run_vecs(14, 2);

        // Mixed fractional widths (operand 1 has 5 fraction bits).
        reset_dut(3);
        run_vecs(16, 3);

        // Broadcast: one operand-1 beat feeds four operand-0 beats.
        reset_dut(2);
        set_in1(mk4(8, 8, 8, 8));
        in1_valid = 1'b1;
        wait_rdy(1, ok);
        @(posedge clk); #1;
        in1_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_in0(mk4(k, k, k, k));
            in0_valid = 1'b1;
            @(negedge clk);
            check("bc_in0_ready", 64'(in0_ready_s), 64'd1);
            check("bc_in1_ready", 64'(in1_ready_s), (k == 3) ? 64'd1 : 64'd0);
            if (in0_ready_s) exp_q.push_back(mk4(8 + k, 8 + k, 8 + k, 8 + k));
            @(posedge clk); #1;
        end
        set_in0(mk4(4, 4, 4, 4));
        hi_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (in0_ready_s) hi_cnt++;
        end
        check("bc_stall_in0_ready_cycles", 64'(hi_cnt), 64'd0);
        check("bc_stall_in1_ready", 64'(in1_ready_s), 64'd1);
        @(posedge clk); #1;
        set_in1(mk4(100, 100, 100, 100));
        in1_valid = 1'b1;
        wait_rdy(1, ok);
        @(posedge clk); #1;
        in1_valid = 1'b0;
        wait_rdy(0, ok);
        if (ok) exp_q.push_back(mk4(104, 104, 104, 104));
        @(posedge clk); #1;
        in0_valid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
        $finish;
    end

endmodule
